// File: rtl/bl_wl_bank_programmer.sv
// Memory-bank configuration writer: shifts a serial bitstream into a row shadow
// register, then drives it on bl while pulsing the matching one-hot word line.
`timescale 1ns/1ps
module bl_wl_bank_programmer #(
    parameter int unsigned BL_WIDTH = 72,
    parameter int unsigned WL_WIDTH = 72,
    parameter int unsigned WL_PULSE = 2
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                cfg_start,
    input  logic                cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [BL_WIDTH-1:0] bl,
    output logic [WL_WIDTH-1:0] wl,
    output logic                busy,
    output logic                done
);
    localparam int unsigned BIT_W  = (BL_WIDTH > 1) ? $clog2(BL_WIDTH) : 1;
    localparam int unsigned ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int unsigned PCNT_W = $clog2(WL_PULSE + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BL_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(WL_WIDTH - 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(WL_PULSE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PULSE,
        RECOVER,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic [PCNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [BL_WIDTH-1:0] shadow_q, shadow_d;

    logic                cfg_ready_q, cfg_ready_d;
    logic [BL_WIDTH-1:0] bl_q, bl_d;
    logic [WL_WIDTH-1:0] wl_q, wl_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // State, counters, shadow and registered outputs
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            row_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            shadow_q    <= '0;
            cfg_ready_q <= 1'b0;
            bl_q        <= '0;
            wl_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            row_cnt_q   <= row_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            shadow_q    <= shadow_d;
            cfg_ready_q <= cfg_ready_d;
            bl_q        <= bl_d;
            wl_q        <= wl_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        row_cnt_d   = row_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        shadow_d    = shadow_q;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    row_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (cfg_valid && cfg_ready_q) begin
                    shadow_d[bit_cnt_q] = cfg_data;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d     = PULSE;
                        pulse_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d = RECOVER;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
                end
            end
            RECOVER: begin
                if (row_cnt_q == ROW_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d   = SHIFT;
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    bit_cnt_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cfg_ready_d = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        bl_d        = ((state_d == PULSE) || (state_d == RECOVER)) ? shadow_d : '0;
        wl_d        = (state_d == PULSE) ? (WL_WIDTH'(1) << row_cnt_d) : '0;
    end

    assign cfg_ready = cfg_ready_q;
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
